divider_8bit_seq: RTL



---
 rtl/divider_8bit_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/divider_8bit_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_8BIT_SEQ_DZ_ERR_EN to add dz_err and a one-cycle fast path for a zero divisor.
module divider_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_8BIT_SEQ_DZ_ERR_EN
  ,
  output logic             dz_err
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shift_in;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_q;

`ifdef DIVIDER_8BIT_SEQ_DZ_ERR_EN
  logic             dz_pending;
`endif

  // Trial subtraction as add-with-inverted-operand; R < D keeps the sign bit meaningful.
  always_comb begin
    shift_in  = {part_rem, work_q[WIDTH-1]};
    trial     = shift_in + ~{1'b0, work_d} + {{WIDTH{1'b0}}, 1'b1};
    trial_neg = trial[WIDTH];
    next_rem  = trial_neg ? shift_in[WIDTH-1:0] : trial[WIDTH-1:0];
    next_q    = {work_q[WIDTH-2:0], ~trial_neg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      part_rem  <= '0;
      work_q    <= '0;
      work_d    <= '0;
      count     <= '0;
`ifdef DIVIDER_8BIT_SEQ_DZ_ERR_EN
      dz_err     <= 1'b0;
      dz_pending <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            part_rem <= '0;
            work_q   <= dividend;
            work_d   <= divisor;
            count    <= CW'(WIDTH - 1);
            state    <= RUN;
`ifdef DIVIDER_8BIT_SEQ_DZ_ERR_EN
            dz_pending <= (divisor == '0);
`endif
          end else begin
            state <= IDLE;
          end
        end

        // Outputs load only on the final iteration so partial results never leak.
        RUN: begin
`ifdef DIVIDER_8BIT_SEQ_DZ_ERR_EN
          if (dz_pending) begin
            dz_pending <= 1'b0;
            quotient   <= '1;
            remainder  <= work_q;
            dz_err     <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else
`endif
          begin
            part_rem <= next_rem;
            work_q   <= next_q;
            count    <= count - CW'(1);
            if (count == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              quotient  <= next_q;
              remainder <= next_rem;
`ifdef DIVIDER_8BIT_SEQ_DZ_ERR_EN
              dz_err    <= 1'b0;
`endif
            end else begin
              busy <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
